// File: rtl/dsp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dsp_pkg                                                       |
// | Brief    : Shared arbiter state encoding, timeout default, grant helper. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
package dsp_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam int DSP_ARB_TIMEOUT = 255;
  localparam int DSP_WDOG_W      = 8;

  function automatic logic [1:0] owner_onehot(input logic owner);
    return owner ? 2'b10 : 2'b01;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dsp_arb_watchdog.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dsp_arb_watchdog                                              |
// | Brief    : Counts stalled bus cycles; flags expiry on the TIMEOUT-th one. |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module dsp_arb_watchdog
  import dsp_pkg::*;
#(
  parameter int TIMEOUT = DSP_ARB_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_active,
  input  logic i_stb,
  input  logic i_term,
  output logic o_expire
);

  // Expiry is flagged combinationally while the count sits one short of the
  // limit, so the error lands on the TIMEOUT-th stalled cycle itself.
  localparam int c_lim_i = (TIMEOUT < 1) ? 0 :
                           ((TIMEOUT > 255) ? 254 : TIMEOUT - 1);
  localparam logic [DSP_WDOG_W-1:0] c_limit = DSP_WDOG_W'(c_lim_i);

  logic [DSP_WDOG_W-1:0] r_count;
  logic                  w_stall;

  assign w_stall  = i_active & i_stb & ~i_term;
  assign o_expire = w_stall & (r_count == c_limit);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (!i_active || i_term || o_expire) begin
      r_count <= '0;
    end else if (w_stall) begin
      r_count <= r_count + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dsp_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : dsp_wb_arbiter                                                |
// | Brief    : Two-requester round-robin Wishbone arbiter. Optional stall    |
// |            watchdog enabled by macro DSP_ARB_TIMEOUT_EN.                  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module dsp_wb_arbiter
  import dsp_pkg::*;
#(
  parameter int dw      = 32,
  parameter int aw      = 32,
  parameter int TIMEOUT = DSP_ARB_TIMEOUT
) (
  input  logic          wb_clk,
  input  logic          wb_rst,
  input  logic [2*aw-1:0] m_adr_i,
  input  logic [2*dw-1:0] m_dat_i,
  input  logic [7:0]    m_sel_i,
  input  logic [1:0]    m_we_i,
  input  logic [1:0]    m_cyc_i,
  input  logic [1:0]    m_stb_i,
  output logic [dw-1:0] m_dat_o,
  output logic [1:0]    m_ack_o,
  output logic [1:0]    m_err_o,
  output logic [1:0]    m_rty_o,
  output logic [aw-1:0] wb_adr_o,
  output logic [dw-1:0] wb_dat_o,
  output logic [3:0]    wb_sel_o,
  output logic          wb_we_o,
  output logic          wb_cyc_o,
  output logic          wb_stb_o,
  input  logic [dw-1:0] wb_dat_i,
  input  logic          wb_ack_i,
  input  logic          wb_err_i,
  input  logic          wb_rty_i,
  output logic [1:0]    grant
);

  arb_state_t r_state, w_state_nxt;
  logic       r_owner, w_owner_nxt;
  logic       r_last_owner, w_last_nxt;
  logic       w_busy;
  logic       w_owner_stb;
  logic       w_term;
  logic       w_expire;

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      r_state      <= ARB_IDLE;
      r_owner      <= 1'b0;
      r_last_owner <= 1'b1;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_owner;
    case (r_state)
      ARB_IDLE: begin
        if (|m_cyc_i) begin
          w_state_nxt = ARB_BUSY;
          // On a tie the requester that did not own the bus last time wins.
          w_owner_nxt = (&m_cyc_i) ? ~r_last_owner : m_cyc_i[1];
        end
      end
      ARB_BUSY: begin
        if (!m_cyc_i[r_owner]) begin
          w_state_nxt = ARB_IDLE;
          w_last_nxt  = r_owner;
        end
      end
      default: w_state_nxt = ARB_IDLE;
    endcase
  end

  assign w_busy      = (r_state == ARB_BUSY);
  assign w_owner_stb = m_stb_i[r_owner] & m_cyc_i[r_owner];
  assign w_term      = wb_ack_i | wb_err_i | wb_rty_i;
  assign m_dat_o     = wb_dat_i;

`ifdef DSP_ARB_TIMEOUT_EN
  dsp_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_wdog (
    .clk      (wb_clk),
    .rst      (wb_rst),
    .i_active (w_busy),
    .i_stb    (w_owner_stb),
    .i_term   (w_term),
    .o_expire (w_expire)
  );
`else
  assign w_expire = 1'b0;
`endif

  always_comb begin
    wb_adr_o = '0;
    wb_dat_o = '0;
    wb_sel_o = '0;
    wb_we_o  = 1'b0;
    wb_cyc_o = 1'b0;
    wb_stb_o = 1'b0;
    grant    = 2'b00;
    m_ack_o  = 2'b00;
    m_err_o  = 2'b00;
    m_rty_o  = 2'b00;
    if (w_busy) begin
      wb_adr_o = r_owner ? m_adr_i[2*aw-1:aw] : m_adr_i[aw-1:0];
      wb_dat_o = r_owner ? m_dat_i[2*dw-1:dw] : m_dat_i[dw-1:0];
      wb_sel_o = r_owner ? m_sel_i[7:4] : m_sel_i[3:0];
      wb_we_o  = m_we_i[r_owner];
      // A watchdog expiry drops the strobe for one cycle to abandon the access.
      wb_cyc_o = m_cyc_i[r_owner] & ~w_expire;
      wb_stb_o = m_stb_i[r_owner] & ~w_expire;
      grant    = owner_onehot(r_owner);
      m_ack_o  = {2{wb_ack_i}} & grant;
      m_err_o  = {2{wb_err_i | w_expire}} & grant;
      m_rty_o  = {2{wb_rty_i}} & grant;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dsp_wb_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_dsp_wb_arbiter                                             |
// | Brief    : Scenario bench for dsp_wb_arbiter with expected-value queue.  |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module tb_dsp_wb_arbiter;

`ifdef DSP_ARB_TIMEOUT_EN
  localparam int c_tmo = 4;
`else
  localparam int c_tmo = 255;
`endif

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic [63:0] m_adr_i = '0;
  logic [63:0] m_dat_i = '0;
  logic [7:0]  m_sel_i = '0;
  logic [1:0]  m_we_i = '0, m_cyc_i = '0, m_stb_i = '0;
  logic [31:0] m_dat_o;
  logic [1:0]  m_ack_o, m_err_o, m_rty_o;
  logic [31:0] wb_adr_o, wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic        wb_we_o, wb_cyc_o, wb_stb_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
  logic [1:0]  grant;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] sb_q[$];
  logic [31:0] exp_v;

  dsp_wb_arbiter #(.dw(32), .aw(32), .TIMEOUT(c_tmo)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
    .m_we_i(m_we_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_we_o(wb_we_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i),
    .wb_rty_i(wb_rty_i), .grant(grant)
  );

  always #5 wb_clk = ~wb_clk;

  // Inputs change 1 time unit after the rising edge; checks follow at +1 more.
  task automatic step();
    @(posedge wb_clk);
    #1;
  endtask

  task automatic release_all();
    m_cyc_i = 2'b00; m_stb_i = 2'b00; m_we_i = 2'b00;
    wb_ack_i = 1'b0; wb_err_i = 1'b0; wb_rty_i = 1'b0;
    step();
    step();
  endtask

  task automatic do_reset();
    wb_rst = 1'b1;
    step();
    wb_rst = 1'b0;
    step();
  endtask

  task automatic test_reset();
    #1;
    vectors++; if (grant !== 2'b00) begin miscompares++; $display("FAIL reset_grant got %b exp 00", grant); end
    vectors++; if ({wb_cyc_o, wb_stb_o} !== 2'b00) begin miscompares++; $display("FAIL reset_cyc_stb got %b exp 00", {wb_cyc_o, wb_stb_o}); end
    vectors++; if ({m_ack_o, m_err_o, m_rty_o} !== 6'b0) begin miscompares++; $display("FAIL reset_term got %b exp 0", {m_ack_o, m_err_o, m_rty_o}); end
    do_reset();
  endtask

  task automatic test_single_write();
    m_adr_i[31:0] = 32'h0000_0010; m_dat_i[31:0] = 32'hDEAD_BEEF; m_sel_i = 8'h0F;
    m_we_i = 2'b01; m_cyc_i = 2'b01; m_stb_i = 2'b01;
    sb_q.push_back(32'h0000_0010); sb_q.push_back(32'hDEAD_BEEF);
    #1;
    vectors++; if (wb_cyc_o !== 1'b0) begin miscompares++; $display("FAIL wr_idle_cyc got %b exp 0", wb_cyc_o); end
    step();
    vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL wr_grant got %b exp 01", grant); end
    vectors++; if ({wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o} !== 7'b111_1111) begin miscompares++; $display("FAIL wr_ctrl got %b exp 1111111", {wb_cyc_o, wb_stb_o, wb_we_o, wb_sel_o}); end
    exp_v = sb_q.pop_front();
    vectors++; if (wb_adr_o !== exp_v) begin miscompares++; $display("FAIL wr_adr got %h exp %h", wb_adr_o, exp_v); end
    exp_v = sb_q.pop_front();
    vectors++; if (wb_dat_o !== exp_v) begin miscompares++; $display("FAIL wr_dat got %h exp %h", wb_dat_o, exp_v); end
    wb_ack_i = 1'b1;
    #1;
    vectors++; if (m_ack_o !== 2'b01) begin miscompares++; $display("FAIL wr_ack got %b exp 01", m_ack_o); end
    release_all();
  endtask

  task automatic test_round_robin();
    do_reset();
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    step();
    vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL rr_first got %b exp 01", grant); end
    release_all();
    m_cyc_i = 2'b11; m_stb_i = 2'b11;
    step();
    vectors++; if (grant !== 2'b10) begin miscompares++; $display("FAIL rr_second got %b exp 10", grant); end
    release_all();
  endtask

  task automatic test_holdoff();
    do_reset();
    m_adr_i = {32'h0000_0B00, 32'h0000_0A00};
    m_cyc_i = 2'b01; m_stb_i = 2'b01;
    sb_q.push_back(32'h0000_0A00);
    step();
    m_cyc_i = 2'b11; m_stb_i = 2'b11; wb_ack_i = 1'b1;
    #1;
    exp_v = sb_q.pop_front();
    vectors++; if (wb_adr_o !== exp_v) begin miscompares++; $display("FAIL hold_adr got %h exp %h", wb_adr_o, exp_v); end
    vectors++; if (m_ack_o !== 2'b01) begin miscompares++; $display("FAIL hold_ack got %b exp 01", m_ack_o); end
    m_stb_i = 2'b10; m_cyc_i = 2'b10; wb_ack_i = 1'b0;
    sb_q.push_back(32'h0000_0B00);
    step();
    vectors++; if ({grant, wb_cyc_o} !== 3'b000) begin miscompares++; $display("FAIL hold_gap got %b exp 000", {grant, wb_cyc_o}); end
    step();
    vectors++; if (grant !== 2'b10) begin miscompares++; $display("FAIL hold_grant got %b exp 10", grant); end
    exp_v = sb_q.pop_front();
    vectors++; if (wb_adr_o !== exp_v) begin miscompares++; $display("FAIL hold_adr1 got %h exp %h", wb_adr_o, exp_v); end
    release_all();
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd [3];
    rd[0] = 32'h11; rd[1] = 32'h22; rd[2] = 32'h33;
    m_cyc_i = 2'b01; m_we_i = 2'b00;
    step();
    for (int i = 0; i < 3; i++) begin
      m_stb_i = 2'b01; wb_dat_i = rd[i]; wb_ack_i = 1'b1;
      sb_q.push_back(rd[i]);
      #1;
      exp_v = sb_q.pop_front();
      vectors++; if (m_dat_o !== exp_v) begin miscompares++; $display("FAIL b2b_dat%0d got %h exp %h", i, m_dat_o, exp_v); end
      vectors++; if ({grant, m_ack_o} !== 4'b0101) begin miscompares++; $display("FAIL b2b_ack%0d got %b exp 0101", i, {grant, m_ack_o}); end
      step();
      m_stb_i = 2'b00; wb_ack_i = 1'b0;
      step();
    end
    vectors++; if (grant !== 2'b01) begin miscompares++; $display("FAIL b2b_hold got %b exp 01", grant); end
    release_all();
  endtask

  task automatic test_timeout();
    m_cyc_i = 2'b01; m_stb_i = 2'b01;
    step();
`ifdef DSP_ARB_TIMEOUT_EN
    for (int c = 1; c <= 5; c++) begin
      logic [2:0] exp_t;
      exp_t = (c == 4) ? 3'b100 : 3'b011;
      vectors++; if ({m_err_o[0], wb_stb_o, wb_cyc_o} !== exp_t) begin miscompares++; $display("FAIL tmo_cyc%0d got %b exp %b", c, {m_err_o[0], wb_stb_o, wb_cyc_o}, exp_t); end
      step();
    end
`else
    repeat (300) step();
    vectors++; if ({grant, m_err_o, wb_stb_o} !== 5'b01_00_1) begin miscompares++; $display("FAIL stall_hold got %b exp 01001", {grant, m_err_o, wb_stb_o}); end
    wb_err_i = 1'b1;
    #1;
    vectors++; if (m_err_o !== 2'b01) begin miscompares++; $display("FAIL err_pass got %b exp 01", m_err_o); end
`endif
    release_all();
  endtask

  task automatic test_reset_mid();
    m_cyc_i = 2'b01; m_stb_i = 2'b01;
    step();
    wb_ack_i = 1'b1;
    #1;
    vectors++; if (m_ack_o !== 2'b01) begin miscompares++; $display("FAIL mid_pre_ack got %b exp 01", m_ack_o); end
    wb_rst = 1'b1;
    #1;
    vectors++; if ({wb_cyc_o, grant, m_ack_o} !== 5'b0) begin miscompares++; $display("FAIL mid_reset got %b exp 00000", {wb_cyc_o, grant, m_ack_o}); end
    step();
    wb_rst = 1'b0;
    release_all();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_holdoff();
    test_back_to_back();
    test_timeout();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dsp_wb_arbiter.md
DSP_WB_ARBITER -- requirements
Module: dsp_wb_arbiter

Interface
REQ-001 SHALL have parameter dw, default 32, data width.
REQ-002 SHALL have parameter aw, default 32, address width.
REQ-003 SHALL have parameter TIMEOUT, default 255, stalled-cycle limit (8-bit counter domain).
REQ-004 SHALL have port wb_clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port wb_rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port m_adr_i  input  2*aw  requester addresses; slice [aw-1:0] is master 0.
REQ-007 SHALL have port m_dat_i  input  2*dw  requester write data.
REQ-008 SHALL have port m_sel_i  input  8  byte selects; 4 per requester.
REQ-009 SHALL have ports m_we_i, m_cyc_i, m_stb_i  input  2 each  per-requester controls.
REQ-010 SHALL have port m_dat_o  output  dw  read data, broadcast to both requesters.
REQ-011 SHALL have ports m_ack_o, m_err_o, m_rty_o  output  2 each  per-requester terminations.
REQ-012 SHALL have ports wb_adr_o aw, wb_dat_o dw, wb_sel_o 4, wb_we_o, wb_cyc_o, wb_stb_o 1  output  shared-bus request.
REQ-013 SHALL have ports wb_dat_i dw, wb_ack_i, wb_err_i, wb_rty_i 1  input  shared-bus response.
REQ-014 SHALL have port grant  output  2  one-hot owner; 2'b00 when idle.

Function
REQ-015 SHALL implement states IDLE and BUSY, plus registered owner bit and last-owner bit.
REQ-016 In IDLE with any m_cyc_i high, SHALL register owner and enter BUSY on the next edge; wb_cyc_o rises one cycle after request.
REQ-017 With both requesting in IDLE, SHALL grant the requester that is not last-owner (round-robin).
REQ-018 In BUSY, SHALL pass owner's adr/dat/sel/we/cyc/stb combinationally to wb_*_o.
REQ-019 In BUSY, SHALL route wb_ack_i/err_i/rty_i only to owner's bit; non-owner bits 0.
REQ-020 m_dat_o SHALL equal wb_dat_i at all times.
REQ-021 In IDLE, all wb_*_o and m_*_o termination bits SHALL be 0.
REQ-022 BUSY SHALL end when owner's m_cyc_i is low; return to IDLE, update last-owner; minimum one IDLE cycle between grants.
REQ-023 Non-owner requests SHALL be held off; its cyc/stb changes SHALL have no effect on the shared bus.
REQ-024 Owner may issue back-to-back stb cycles under one cyc without re-arbitration.

Reset
REQ-025 Reset SHALL force IDLE, grant 0, last-owner 1 (master 0 wins first tie), timeout count 0, all outputs 0 immediately, including mid-transfer.

Configuration
REQ-026 With DSP_ARB_TIMEOUT_EN defined, SHALL count BUSY cycles with wb_stb_o high and no ack/err/rty; count clears on any termination or on leaving BUSY.
REQ-027 With DSP_ARB_TIMEOUT_EN defined, when count reaches TIMEOUT SHALL pulse owner's m_err_o one cycle, force wb_cyc_o/wb_stb_o low that cycle, clear count.
REQ-028 Without DSP_ARB_TIMEOUT_EN, SHALL have no counter; err is pure pass-through; a stalled slave holds the bus indefinitely.

Structure
REQ-029 State encodings and the TIMEOUT default SHALL live in shared package dsp_pkg.
REQ-030 Timeout counter SHALL be sub-module dsp_arb_watchdog, instantiated only under DSP_ARB_TIMEOUT_EN.

Verification
REQ-031 Master 0 alone writes 32'hDEAD_BEEF to 32'h0000_0010 -> grant=01 one cycle after cyc, wb_dat_o=DEAD_BEEF, m_ack_o=01 on wb_ack_i.
REQ-032 Both request same cycle after reset -> master 0 granted; after release, both again -> master 1 granted.
REQ-033 Master 1 requests while master 0 owns -> m_ack_o[1]=0, wb_adr_o unchanged, grant=10 after one IDLE cycle.
REQ-034 Owner holds cyc with three stb/ack beats, reads 11, 22, 33 -> no grant change, m_dat_o follows wb_dat_i.
REQ-035 Macro on, TIMEOUT=4, slave never acks -> m_err_o owner bit pulses on stalled cycle 4, wb_stb_o low that cycle.
REQ-036 wb_rst asserted mid-transfer -> wb_cyc_o, grant, m_ack_o all 0 without waiting for a clock edge.
